operand_streamer: RTL

OPERAND_STREAMER -- requirements
Module: operand_streamer

---
 rtl/operand_streamer_if.sv | 38 +++
 rtl/operand_streamer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/operand_streamer_if.sv
// Purpose: load port and streamed-operand bus of operand_streamer, bundled for module ports.
// Latency: none, wires only; timing is set by the producer and the consumer.
// Backpressure: none; the stream side is valid-only and the load side is a plain strobe.
interface operand_streamer_if #(
   parameter int Nbits = 4,
   parameter int Ndata = 4
);
   localparam int Wi = $clog2(Ndata);

   // element load port
   logic                   load_en;
   logic                   load_sel;
   logic [Wi-1:0]          load_row;
   logic [Wi-1:0]          load_col;
   logic [Nbits-1:0]       load_data;
   logic                   start;

   // streamed operand pair and status
   logic [Ndata*Nbits-1:0] A;
   logic [Ndata*Nbits-1:0] B;
   logic                   valid;
   logic [Wi-1:0]          row_idx;
   logic [Wi-1:0]          col_idx;
   logic                   busy;
   logic                   done;

   // the side that loads matrices and requests streams
   modport master (
      output load_en, load_sel, load_row, load_col, load_data, start,
      input  A, B, valid, row_idx, col_idx, busy, done
   );

   // the streamer itself
   modport slave (
      input  load_en, load_sel, load_row, load_col, load_data, start,
      output A, B, valid, row_idx, col_idx, busy, done
   );
endinterface

// File: rtl/operand_streamer.sv
// Purpose: holds matrices A and B and streams every (row of A, column of B) pair in row-major order.
// Latency: pair 0 appears one cycle after the start edge, one pair per cycle, done one cycle after the last pair.
// Backpressure: none; the consumer must take one pair per cycle, and loads/starts while busy are dropped.
module operand_streamer #(
   parameter int Nbits = 4,
   parameter int Ndata = 4
) (
   input logic                clk,
   input logic                reset,
   operand_streamer_if.slave  bus
);
   localparam int Wi = $clog2(Ndata);
   localparam int Cw = 2 * Wi;
   localparam int W  = Ndata * Nbits;

   localparam logic [Wi-1:0] IdxMax   = Wi'(Ndata - 1);
   localparam logic [Cw-1:0] LastPair = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state;

   // pair counter: upper Wi bits select the row, lower Wi bits the column
   logic [Cw-1:0]     pair_cnt;

   // operand storage, intentionally left unreset so contents survive a reset
   logic [Nbits-1:0]  matA [Ndata][Ndata];
   logic [Nbits-1:0]  matB [Ndata][Ndata];

   logic [Wi-1:0]     cur_row;
   logic [Wi-1:0]     cur_col;
   logic [W-1:0]      a_row;
   logic [W-1:0]      b_col;

   // registered outputs
   logic [W-1:0]      a_q;
   logic [W-1:0]      b_q;
   logic [Wi-1:0]     row_q;
   logic [Wi-1:0]     col_q;
   logic              valid_q;
   logic              done_q;
   logic              last_sent;
   logic              wr_ok;

   assign cur_row = pair_cnt[Cw-1:Wi];
   assign cur_col = pair_cnt[Wi-1:0];

   // the pair currently registered on the outputs is the final one of the stream
   assign last_sent = valid_q && (row_q == IdxMax) && (col_q == IdxMax);

   // loads only land while idle and out of reset; start in the same cycle still sees the new value
   assign wr_ok = reset && bus.load_en && (state == IDLE);

   // Element write port into the selected matrix.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         if (bus.load_sel) begin
            matB[bus.load_row][bus.load_col] <= bus.load_data;
         end else begin
            matA[bus.load_row][bus.load_col] <= bus.load_data;
         end
      end
   end

   // Gather row cur_row of A and column cur_col of B into packed lane vectors.
   always_comb begin
      a_row = '0;
      b_col = '0;
      for (int k = 0; k < Ndata; k++) begin
         a_row[k*Nbits +: Nbits] = matA[cur_row][k];
         b_col[k*Nbits +: Nbits] = matB[k][cur_col];
      end
   end

   // Stream sequencer: IDLE waits for start, STREAM emits one pair per cycle, DONE pulses done.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         pair_cnt <= '0;
         a_q      <= '0;
         b_q      <= '0;
         row_q    <= '0;
         col_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               valid_q <= 1'b0;
               done_q  <= 1'b0;
               if (bus.start) begin
                  state    <= STREAM;
                  pair_cnt <= '0;
               end
            end

            STREAM: begin
               if (last_sent) begin
                  // final pair has had its cycle on the outputs; data lanes keep their last value
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end else begin
                  a_q     <= a_row;
                  b_q     <= b_col;
                  row_q   <= cur_row;
                  col_q   <= cur_col;
                  valid_q <= 1'b1;
                  // saturate on the last pair so the count never wraps inside a stream
                  if (pair_cnt != LastPair) begin
                     pair_cnt <= pair_cnt + Cw'(1);
                  end
               end
            end

            DONE: begin
               // start here is deliberately not looked at; a new stream needs an IDLE cycle
               done_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.A       = a_q;
   assign bus.B       = b_q;
   assign bus.row_idx = row_q;
   assign bus.col_idx = col_q;
   assign bus.valid   = valid_q;
   assign bus.done    = done_q;
   assign bus.busy    = (state != IDLE);
endmodule
